sub_bytes_seq: RTL

- Iterative AES SubBytes stage. Accepts a 128-bit AES state over a valid/ready handshake.
- Substitutes all 16 bytes through LANES shared sbox_LUT instances, LANES bytes per cycle, then presents the 128-bit result on a valid/ready output.
- Sits directly upstream of the sbox_LUT instances, which it drives, and feeds ShiftRows.
- Trades area (few S-boxes) for latency.

---
 rtl/aes_pkg.sv | 17 +
 rtl/sbox_LUT.sv | 29 ++
 rtl/sub_bytes_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, state type and SubBytes FSM encoding
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    // Byte 0 sits at index 0, which is the most significant byte of the flat state
    typedef logic [0:AES_NUM_BYTES-1][AES_BYTE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

endpackage

// File: rtl/sbox_LUT.sv
// rtl/sbox_LUT.sv - AES forward S-box as a 256-entry lookup table
module sbox_LUT (
    input  logic [7:0] byte_in,
    output logic [7:0] sbyte
);

    // Entry 0 is the most significant byte; each literal is one row of 16 entries
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sbyte = SBOX[byte_in];

endmodule

// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - iterative AES SubBytes over LANES shared S-boxes
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int NUM_BYTES = AES_NUM_BYTES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int IDX_W = $clog2(AES_NUM_BYTES);

    if (NUM_BYTES != AES_NUM_BYTES ||
        !(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_cfg
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16 and NUM_BYTES must be 16");
    end

    aes_fsm_e               state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    aes_state_t             buf_q, buf_d;
    logic [LANES-1:0][7:0]  lane_in;
    logic [LANES-1:0][7:0]  lane_out;
    logic                   last_step;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sbox_LUT u_sbox (
            .byte_in (lane_in[k]),
            .sbyte   (lane_out[k])
        );
    end

    // Lane k looks at byte idx+k; idx is always a multiple of LANES so this never wraps mid-pass
    always_comb begin
        lane_in = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_in[k] = buf_q[idx_q + IDX_W'(k)];
        end
    end

    // Wide compare so LANES=16 does not alias to zero in the 4-bit index
    assign last_step = (({1'b0, idx_q} + (IDX_W+1)'(LANES)) == (IDX_W+1)'(NUM_BYTES));

    // State, index and buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state: accept in IDLE, sweep bytes in BUSY, wait for the output handshake in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready) state_d = BUSY;
            BUSY:    if (last_step)            state_d = DONE;
            DONE:    if (out_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Datapath: latch the input on accept, write substituted bytes back in place while busy
    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    buf_d = aes_state_t'(in_state);
                    idx_d = '0;
                end
            end
            BUSY: begin
                for (int k = 0; k < LANES; k++) begin
                    buf_d[idx_q + IDX_W'(k)] = lane_out[k];
                end
                idx_d = idx_q + IDX_W'(LANES);
            end
            default: ;
        endcase
    end

    // Handshake outputs decode the registered state only; out_ready never reaches in_ready directly
    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        out_valid = (state_q == DONE);
        out_state = AES_STATE_W'(buf_q);
    end

endmodule
